// File: rtl/csr_pkg.sv
// Shared definitions for the CSR side-bus peripherals: modify opcodes,
// UART engine states and data-CSR status bit positions.
package csr_pkg;

    localparam logic [2:0] MOD_WRITE = 3'b001;
    localparam logic [2:0] MOD_SET   = 3'b010;
    localparam logic [2:0] MOD_CLEAR = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int STAT_RX_EMPTY     = 8;
    localparam int STAT_RX_FRAME_ERR = 9;
    localparam int STAT_RX_OVERRUN   = 10;
    localparam int STAT_TX_FULL      = 11;

    // A 256-entry FIFO has a 9-bit count; saturate so "full" never reads as 0.
    function automatic logic [7:0] count8(input logic [8:0] c);
        return c[8] ? 8'hff : c[7:0];
    endfunction

endpackage

// File: rtl/csr_uart_fifo_buf.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit so
// count = wr - rd. A push on a full FIFO succeeds only if a pop happens in the same cycle.
module csr_uart_fifo_buf #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic [WIDTH-1:0]      head
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/csr_uart_fifo.sv
// Buffered CSR UART: data/status CSR at BASE_ADDR, control CSR at BASE_ADDR+1.
// Optional interrupt output and enable register under CSR_UART_FIFO_IRQ_EN.
module csr_uart_fifo
    import csr_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR     = 12'hbc0,
    parameter int          CLOCK_RATE    = 12_000_000,
    parameter int          BAUD_RATE     = 115200,
    parameter int          RX_DEPTH_LOG2 = 4,
    parameter int          TX_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        rx,
    output logic        tx,
`ifdef CSR_UART_FIFO_IRQ_EN
    output logic        irq,
`endif
    output logic        avoid_warning
);

    localparam logic [15:0] DIV_RESET = 16'(CLOCK_RATE / BAUD_RATE);

    logic hit_data, hit_ctrl, tx_push, rx_pop, clr_frame, clr_over, div_wr;
    logic [15:0] divisor;
    logic rx_frame_err, rx_overrun;
    logic [31:0] rd_next;

    logic tx_full, tx_empty, tx_pop;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic [7:0] tx_head;
    logic rx_full, rx_empty, rx_push, frame_set;
    logic [RX_DEPTH_LOG2:0] rx_count;
    logic [7:0] rx_head;

    assign hit_data  = (addr == BASE_ADDR);
    assign hit_ctrl  = (addr == BASE_ADDR + 12'd1);
    assign tx_push   = hit_data & (modify == MOD_WRITE);
    assign rx_pop    = hit_data & (modify == MOD_SET) & wdata[0];
    assign clr_frame = hit_data & (modify == MOD_CLEAR) & wdata[1];
    assign clr_over  = hit_data & (modify == MOD_CLEAR) & wdata[2];
    assign div_wr    = hit_ctrl & (modify == MOD_WRITE);
    assign avoid_warning = read | (|wdata[31:16]);

`ifdef CSR_UART_FIFO_IRQ_EN
    logic [1:0] irq_en;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en <= 2'b00;
            irq    <= 1'b0;
        end else begin
            if (hit_ctrl && modify == MOD_SET)   irq_en <= irq_en | wdata[17:16];
            if (hit_ctrl && modify == MOD_CLEAR) irq_en <= irq_en & ~wdata[17:16];
            irq <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty);
        end
    end
`endif

    always_comb begin
        rd_next = '0;
        if (hit_data) begin
            rd_next[7:0]               = rx_head;
            rd_next[STAT_RX_EMPTY]     = rx_empty;
            rd_next[STAT_RX_FRAME_ERR] = rx_frame_err;
            rd_next[STAT_RX_OVERRUN]   = rx_overrun;
            rd_next[STAT_TX_FULL]      = tx_full;
        end else if (hit_ctrl) begin
            rd_next = {count8(9'(tx_count)), count8(9'(rx_count)), divisor};
`ifdef CSR_UART_FIFO_IRQ_EN
            rd_next[17:16] = irq_en;
`endif
        end
    end

    // Sticky error flags: a new event in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid        <= 1'b0;
            rdata        <= '0;
            divisor      <= DIV_RESET;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            valid <= hit_data | hit_ctrl;
            rdata <= rd_next;
            if (div_wr) divisor <= (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
            if (frame_set)      rx_frame_err <= 1'b1;
            else if (clr_frame) rx_frame_err <= 1'b0;
            if (rx_push & rx_full & ~rx_pop) rx_overrun <= 1'b1;
            else if (clr_over)               rx_overrun <= 1'b0;
        end
    end

    csr_uart_fifo_buf #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .push_data(wdata[7:0]), .pop(tx_pop),
        .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_head)
    );

    // ---------------- TX engine ----------------
    uart_state_t tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shreg, tx_shreg_n;
    logic        tx_bit_end;

    assign tx_bit_end = (tx_cnt == tx_div - 16'd1);
    assign tx = (tx_state == ST_START) ? 1'b0 :
                (tx_state == ST_DATA)  ? tx_shreg[0] : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_div   <= DIV_RESET;
            tx_bit   <= '0;
            tx_shreg <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_shreg <= tx_shreg_n;
        end
    end

    // Divisor is latched at each start bit so a frame in flight keeps its rate.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shreg_n = tx_shreg;
        tx_pop     = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                tx_cnt_n = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shreg_n = tx_head;
                    tx_div_n   = divisor;
                    tx_state_n = ST_START;
                end
            end
            ST_START: if (tx_bit_end) begin
                tx_cnt_n   = '0;
                tx_bit_n   = '0;
                tx_state_n = ST_DATA;
            end
            ST_DATA: if (tx_bit_end) begin
                tx_cnt_n   = '0;
                tx_shreg_n = {1'b0, tx_shreg[7:1]};
                tx_bit_n   = tx_bit + 3'd1;
                if (tx_bit == 3'd7) tx_state_n = ST_STOP;
            end
            ST_STOP: if (tx_bit_end) begin
                tx_cnt_n = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shreg_n = tx_head;
                    tx_div_n   = divisor;
                    tx_state_n = ST_START;
                end else begin
                    tx_state_n = ST_IDLE;
                end
            end
            default: tx_state_n = ST_IDLE;
        endcase
    end

    // ---------------- RX engine ----------------
    uart_state_t rx_state, rx_state_n;
    logic        rx_s1, rx_s2, rx_s3;
    logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shreg, rx_shreg_n;
    logic        rx_brk, rx_brk_n;

    csr_uart_fifo_buf #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .push_data(rx_shreg), .pop(rx_pop),
        .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rx_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_RESET;
            rx_bit   <= '0;
            rx_shreg <= '0;
            rx_brk   <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_shreg <= rx_shreg_n;
            rx_brk   <= rx_brk_n;
        end
    end

    // rx_brk: stop bit sampled low; hold in STOP until the line returns high.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_shreg_n = rx_shreg;
        rx_brk_n   = rx_brk;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                rx_cnt_n = '0;
                if (rx_s3 && !rx_s2) begin
                    rx_div_n   = divisor;
                    rx_state_n = ST_START;
                end
            end
            ST_START: if (rx_cnt == {1'b0, rx_div[15:1]}) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_s2 ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rx_cnt == rx_div - 16'd1) begin
                rx_cnt_n   = '0;
                rx_shreg_n = {rx_s2, rx_shreg[7:1]};
                rx_bit_n   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_n = ST_STOP;
            end
            ST_STOP: begin
                if (rx_brk) begin
                    rx_cnt_n = '0;
                    if (rx_s2) begin
                        rx_brk_n   = 1'b0;
                        rx_state_n = ST_IDLE;
                    end
                end else if (rx_cnt == rx_div - 16'd1) begin
                    rx_cnt_n = '0;
                    if (rx_s2) begin
                        rx_push    = 1'b1;
                        rx_state_n = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        rx_brk_n  = 1'b1;
                    end
                end
            end
            default: rx_state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_uart_fifo.sv
// Bench for csr_uart_fifo at divisor 10, 2-entry RX FIFO and 4-entry TX FIFO.
module tb_csr_uart_fifo;

  localparam logic [11:0] BASE = 12'hbc0;
  localparam logic [11:0] CTRL = 12'hbc1;
  localparam int DIV = 10;
  localparam int TX_CAP = 4;
  localparam int RX_CAP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic [2:0]  modify = 3'b000;
  logic [31:0] wdata = '0;
  logic [11:0] addr = '0;
  logic [31:0] rdata;
  logic        valid;
  logic        rx = 1'b1;
  logic        tx;
  logic        avoid_warning;
`ifdef CSR_UART_FIFO_IRQ_EN
  logic        irq;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [8:0] got_q[$];
  int         start_q[$];

  csr_uart_fifo #(
    .BASE_ADDR(BASE), .CLOCK_RATE(1_000_000), .BAUD_RATE(100_000),
    .RX_DEPTH_LOG2(1), .TX_DEPTH_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst), .read(read), .modify(modify), .wdata(wdata), .addr(addr),
    .rdata(rdata), .valid(valid), .rx(rx), .tx(tx),
`ifdef CSR_UART_FIFO_IRQ_EN
    .irq(irq),
`endif
    .avoid_warning(avoid_warning)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic csr_cycle(input logic [11:0] a, input logic [2:0] m, input logic [31:0] d,
                           output logic v, output logic [31:0] r);
    @(negedge clk);
    addr = a; modify = m; wdata = d;
    @(posedge clk);
    #1;
    v = valid; r = rdata;
    addr = 12'h000; modify = 3'b000; wdata = '0;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] r);
    logic v;
    csr_cycle(a, 3'b000, 32'h0, v, r);
  endtask

  task automatic csr_op(input logic [11:0] a, input logic [2:0] m, input logic [31:0] d);
    logic v;
    logic [31:0] r;
    csr_cycle(a, m, d, v, r);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  // ---------------- serial TX monitor ----------------
  initial begin : tx_monitor
    logic [7:0] d;
    logic       s;
    int         t0;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        t0 = cyc;
        repeat (DIV / 2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (DIV) @(negedge clk);
          d[b] = tx;
        end
        repeat (DIV) @(negedge clk);
        s = tx;
        got_q.push_back({s, d});
        start_q.push_back(t0);
      end
    end
  end

  task automatic check_frames(input string tag);
    check($sformatf("%s frame_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s frame%0d", tag, i), 32'(got_q[i]), {23'b0, 1'b1, exp_q[i]});
      if (i > 0)
        check($sformatf("%s gap%0d", tag, i), 32'(start_q[i] - start_q[i-1]), 32'(DIV * 10));
    end
    exp_q.delete(); got_q.delete(); start_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [11:0] a;
    logic [2:0]  m;
    logic [31:0] d;
    logic        exp_valid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[17];

  initial begin : main
    logic        v;
    logic [31:0] r;
    logic [7:0]  b;
    logic [7:0]  rx_model[$];
    logic        ovr;
    int          n;

    vt[0]  = '{CTRL, 3'b000, 32'h0,         1'b1, 32'h0000_000A};
    vt[1]  = '{BASE, 3'b000, 32'h0,         1'b1, 32'h0000_0100};
    vt[2]  = '{12'h123, 3'b000, 32'h0,      1'b0, 32'h0};
    vt[3]  = '{CTRL, 3'b001, 32'h1,         1'b1, 32'h0000_000A};
    vt[4]  = '{CTRL, 3'b000, 32'h0,         1'b1, 32'h0000_0002};
    vt[5]  = '{CTRL, 3'b001, 32'hFFFF_0000, 1'b1, 32'h0000_0002};
    vt[6]  = '{CTRL, 3'b000, 32'h0,         1'b1, 32'h0000_0002};
    vt[7]  = '{CTRL, 3'b001, 32'h0000_000A, 1'b1, 32'h0000_0002};
    vt[8]  = '{CTRL, 3'b000, 32'h0,         1'b1, 32'h0000_000A};
    vt[9]  = '{BASE, 3'b010, 32'h1,         1'b1, 32'h0000_0100};
    vt[10] = '{BASE, 3'b011, 32'h6,         1'b1, 32'h0000_0100};
    vt[11] = '{BASE, 3'b000, 32'h0,         1'b1, 32'h0000_0100};
    vt[12] = '{12'hbbf, 3'b000, 32'h0,      1'b0, 32'h0};
    vt[13] = '{CTRL, 3'b010, 32'h0003_0000, 1'b1, 32'h0000_000A};
`ifdef CSR_UART_FIFO_IRQ_EN
    vt[14] = '{CTRL, 3'b000, 32'h0,         1'b1, 32'h0003_000A};
    vt[15] = '{CTRL, 3'b011, 32'h0003_0000, 1'b1, 32'h0003_000A};
`else
    vt[14] = '{CTRL, 3'b000, 32'h0,         1'b1, 32'h0000_000A};
    vt[15] = '{CTRL, 3'b011, 32'h0003_0000, 1'b1, 32'h0000_000A};
`endif
    vt[16] = '{CTRL, 3'b000, 32'h0,         1'b1, 32'h0000_000A};

    // reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset tx", 32'(tx), 32'h1);
    check("reset valid", 32'(valid), 32'h0);
    check("reset rdata", rdata, 32'h0);

    for (int i = 0; i < 17; i++) begin
      csr_cycle(vt[i].a, vt[i].m, vt[i].d, v, r);
      check($sformatf("vec%0d valid", i), 32'(v), 32'(vt[i].exp_valid));
      check($sformatf("vec%0d rdata", i), r, vt[i].exp_rdata);
    end

    // two back-to-back TX frames
    csr_op(BASE, 3'b001, 32'h55); exp_q.push_back(8'h55);
    csr_op(BASE, 3'b001, 32'hA3); exp_q.push_back(8'hA3);
    csr_rd(CTRL, r);
    check("tx_count busy", 32'(r[31:24]), 32'd1);
    repeat (110) @(negedge clk);
    csr_rd(CTRL, r);
    check("tx_count drained", 32'(r[31:24]), 32'd0);
    repeat (120) @(negedge clk);
    check_frames("b2b");

    // overfill TX: engine takes the first byte, TX_CAP buffered, rest dropped
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      csr_op(BASE, 3'b001, {24'h0, b});
      if (i < 1 + TX_CAP) exp_q.push_back(b);
    end
    csr_rd(BASE, r);
    check("tx_full", 32'(r[11]), 32'd1);
    csr_rd(CTRL, r);
    check("tx_count full", 32'(r[31:24]), 32'(TX_CAP));
    repeat (DIV * 10 * 6 + 30) @(negedge clk);
    check_frames("overfill");

    // random TX bursts
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 1 + TX_CAP);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        csr_op(BASE, 3'b001, {24'h0, b});
        exp_q.push_back(b);
      end
      repeat (n * DIV * 10 + 30) @(negedge clk);
      check_frames($sformatf("rand_tx%0d", k));
    end

    // RX directed: good frame, pop, framing error, clear
    send_rx(8'h3C, 1'b1);
    csr_rd(BASE, r);
    check("rx 3C", r, 32'h0000_003C);
    csr_op(BASE, 3'b010, 32'h1);
    csr_rd(BASE, r);
    check("rx popped", r, 32'h0000_0100);
    send_rx(8'hA5, 1'b0);
    csr_rd(BASE, r);
    check("rx frame_err", r, 32'h0000_0300);
    csr_rd(CTRL, r);
    check("rx frame_err count", r, 32'h0000_000A);
    csr_op(BASE, 3'b011, 32'h2);
    csr_rd(BASE, r);
    check("rx frame_err clr", r, 32'h0000_0100);

    // RX overrun: three frames into a two-entry FIFO
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    send_rx(8'h33, 1'b1);
    csr_rd(CTRL, r);
    check("rx_count full", r, 32'h0002_000A);
    csr_rd(BASE, r);
    check("ovr head1", r, 32'h0000_0411);
    csr_op(BASE, 3'b010, 32'h1);
    csr_rd(BASE, r);
    check("ovr head2", r, 32'h0000_0422);
    csr_op(BASE, 3'b010, 32'h1);
    csr_rd(BASE, r);
    check("ovr empty", r, 32'h0000_0500);
    csr_op(BASE, 3'b011, 32'h4);
    csr_rd(BASE, r);
    check("ovr clr", r, 32'h0000_0100);

    // random RX bursts against a bounded-queue model
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 3);
      ovr = 1'b0;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        send_rx(b, 1'b1);
        if (rx_model.size() < RX_CAP) rx_model.push_back(b);
        else ovr = 1'b1;
      end
      while (rx_model.size() > 0) begin
        b = rx_model.pop_front();
        csr_rd(BASE, r);
        check($sformatf("rand_rx%0d head", k), r, {21'h0, ovr, 2'b00, b});
        csr_op(BASE, 3'b010, 32'h1);
      end
      csr_rd(BASE, r);
      check($sformatf("rand_rx%0d empty", k), r, {21'h0, ovr, 10'h100});
      csr_op(BASE, 3'b011, 32'h4);
    end

    // reset in the middle of a slow TX frame
    csr_op(CTRL, 3'b001, 32'd20);
    csr_rd(CTRL, r);
    check("div 20", r, 32'h0000_0014);
    csr_op(BASE, 3'b001, 32'h00);
    csr_op(BASE, 3'b001, 32'h00);
    repeat (40) @(negedge clk);
    check("tx low mid-frame", 32'(tx), 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("tx on reset", 32'(tx), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    csr_rd(CTRL, r);
    check("ctrl after reset", r, 32'h0000_000A);
    csr_rd(BASE, r);
    check("data after reset", r, 32'h0000_0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
